// File: rtl/ni_pkg.sv
// Shared definitions for the neighbour-intensity coder: compare modes and the
// circular transition counter used for uniform-code classification.
package ni_pkg;

  localparam logic [1:0] NI_MODE_GE  = 2'd0;
  localparam logic [1:0] NI_MODE_GT  = 2'd1;
  localparam logic [1:0] NI_MODE_INV = 2'd2;

  localparam int NI_MAX_NB = 16;

  // Popcount of code ^ rotate_right(code,1) over the low n bits (circular).
  function automatic logic [4:0] ni_transitions(input logic [NI_MAX_NB-1:0] code, input int n);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int k = 0; k < NI_MAX_NB; k++) begin
      if (k < n) begin
        cnt = cnt + {4'd0, code[k] ^ code[(k + 1) % n]};
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ni_compare_lane.sv
// One neighbour lane: compares a shifted neighbour sum against the gained centre
// sum under the selected mode and yields the code bit for that lane.
module ni_compare_lane
  import ni_pkg::*;
#(
  parameter int W = 24
) (
  input  logic [W-1:0] lhs_i,
  input  logic [W-1:0] rhs_i,
  input  logic [1:0]   mode_i,
  output logic         bit_o
);

  logic ge_s;

  // Mode select; the reserved encoding falls back to the GE compare.
  always_comb begin
    ge_s  = (lhs_i >= rhs_i);
    bit_o = ge_s;
    case (mode_i)
      NI_MODE_GE:  bit_o = ge_s;
      NI_MODE_GT:  bit_o = (lhs_i > rhs_i);
      NI_MODE_INV: bit_o = ~ge_s;
      default:     bit_o = ge_s;
    endcase
  end

endmodule

// File: rtl/ni_code_engine.sv
// Neighbour-intensity coder: two-stage pipeline producing a packed code and
// uniform flag per pixel, plus saturating per-frame code/uniform statistics.
module ni_code_engine
  import ni_pkg::*;
#(
  parameter int WIDTH   = 10,
  parameter int S_WIDTH = 24,
  parameter int NUM_NB  = 8,
  parameter int GAIN    = 25,
  parameter int SHIFT   = 0,
  parameter int CNT_W   = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      done_i,
  input  logic                      progress_done_i,
  input  logic [1:0]                mode_i,
  input  logic [NUM_NB*S_WIDTH-1:0] s_i,
  input  logic [WIDTH-1:0]          sum_i,
  output logic                      done_o,
  output logic [NUM_NB-1:0]         code_o,
  output logic                      uniform_o,
  output logic                      progress_done_o,
  output logic                      frame_valid_o,
  output logic [CNT_W-1:0]          frame_code_cnt_o,
  output logic [CNT_W-1:0]          frame_uniform_cnt_o
);

  localparam int RHS_W = WIDTH + $clog2(GAIN + 1);
  localparam int LHS_W = S_WIDTH + SHIFT;
  localparam int CMP_W = (RHS_W > LHS_W) ? RHS_W : LHS_W;
  localparam logic [RHS_W-1:0] GAIN_C = RHS_W'(GAIN);

  logic                      v1_q;
  logic [RHS_W-1:0]          rhs_q;
  logic [NUM_NB*S_WIDTH-1:0] s_q;
  logic [1:0]                mode_q;
  logic                      pd1_q, pd2_q;
  logic                      done_q, uniform_q, frame_valid_q;
  logic [NUM_NB-1:0]         code_q;
  logic [CNT_W-1:0]          code_acc_q, uni_acc_q, code_acc_d, uni_acc_d;
  logic [CNT_W-1:0]          frame_code_q, frame_uni_q;
  logic [CNT_W-1:0]          code_tot_s, uni_tot_s;
  logic [RHS_W-1:0]          rhs_s;
  logic [NUM_NB-1:0]         cmp_s;
  logic [4:0]                trans_s;
  logic                      uniform_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a, input logic inc);
    if (inc && (a != {CNT_W{1'b1}})) begin
      return a + CNT_W'(1'b1);
    end else begin
      return a;
    end
  endfunction

  assign rhs_s = RHS_W'(sum_i) * GAIN_C;

  // Stage 1: capture operands for the pixel presented with done_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      rhs_q  <= '0;
      s_q    <= '0;
      mode_q <= NI_MODE_GE;
    end else begin
      v1_q <= done_i;
      if (done_i) begin
        rhs_q  <= rhs_s;
        s_q    <= s_i;
        mode_q <= mode_i;
      end
    end
  end

  for (genvar k = 0; k < NUM_NB; k++) begin : g_lane
    logic [CMP_W-1:0] lhs_s;
    logic [CMP_W-1:0] rhs_ext_s;
    assign lhs_s     = CMP_W'(s_q[k*S_WIDTH +: S_WIDTH]) << SHIFT;
    assign rhs_ext_s = CMP_W'(rhs_q);
    ni_compare_lane #(.W(CMP_W)) u_lane (
      .lhs_i  (lhs_s),
      .rhs_i  (rhs_ext_s),
      .mode_i (mode_q),
      .bit_o  (cmp_s[k])
    );
  end

  assign trans_s   = ni_transitions(NI_MAX_NB'(cmp_s), NUM_NB);
  assign uniform_s = (trans_s <= 5'd2);

  // Stage 2: register code/uniform (held while idle) and the aligned progress delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q    <= 1'b0;
      code_q    <= '0;
      uniform_q <= 1'b0;
      pd1_q     <= 1'b0;
      pd2_q     <= 1'b0;
    end else begin
      done_q <= v1_q;
      pd1_q  <= progress_done_i;
      pd2_q  <= pd1_q;
      if (v1_q) begin
        code_q    <= cmp_s;
        uniform_q <= uniform_s;
      end
    end
  end

  // A frame closing on a code cycle reports that code and also seeds the next frame with it.
  always_comb begin
    code_tot_s = sat_inc(code_acc_q, done_q);
    uni_tot_s  = sat_inc(uni_acc_q, done_q & uniform_q);
    if (pd2_q) begin
      code_acc_d = CNT_W'(done_q);
      uni_acc_d  = CNT_W'(done_q & uniform_q);
    end else begin
      code_acc_d = code_tot_s;
      uni_acc_d  = uni_tot_s;
    end
  end

  // Accumulators and frame snapshot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_acc_q    <= '0;
      uni_acc_q     <= '0;
      frame_code_q  <= '0;
      frame_uni_q   <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      code_acc_q    <= code_acc_d;
      uni_acc_q     <= uni_acc_d;
      frame_valid_q <= pd2_q;
      if (pd2_q) begin
        frame_code_q <= code_tot_s;
        frame_uni_q  <= uni_tot_s;
      end
    end
  end

  assign done_o              = done_q;
  assign code_o              = code_q;
  assign uniform_o           = uniform_q;
  assign progress_done_o     = pd2_q;
  assign frame_valid_o       = frame_valid_q;
  assign frame_code_cnt_o    = frame_code_q;
  assign frame_uniform_cnt_o = frame_uni_q;

endmodule

// File: tb/tb_ni_code_engine.sv
// Scoreboard bench for ni_code_engine: a reference model predicts codes and frame
// statistics at issue time; a monitor pops and compares when the DUT responds.
module tb_ni_code_engine;

  localparam int NB = 8;
  localparam int SW = 24;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            done_i = 1'b0;
  logic            progress_done_i = 1'b0;
  logic [1:0]      mode_i = 2'd0;
  logic [NB*SW-1:0] s_i = '0;
  logic [9:0]      sum_i = 10'd0;

  logic            done_o, uniform_o, progress_done_o, frame_valid_o;
  logic [NB-1:0]   code_o;
  logic [19:0]     frame_code_cnt_o, frame_uniform_cnt_o;
  logic            s_done_o, s_uniform_o, s_progress_done_o, s_frame_valid_o;
  logic [NB-1:0]   s_code_o;
  logic [3:0]      s_frame_code_cnt_o, s_frame_uniform_cnt_o;

  ni_code_engine dut (
    .clk(clk), .rst(rst), .done_i(done_i), .progress_done_i(progress_done_i),
    .mode_i(mode_i), .s_i(s_i), .sum_i(sum_i), .done_o(done_o), .code_o(code_o),
    .uniform_o(uniform_o), .progress_done_o(progress_done_o), .frame_valid_o(frame_valid_o),
    .frame_code_cnt_o(frame_code_cnt_o), .frame_uniform_cnt_o(frame_uniform_cnt_o)
  );

  ni_code_engine #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .done_i(done_i), .progress_done_i(progress_done_i),
    .mode_i(mode_i), .s_i(s_i), .sum_i(sum_i), .done_o(s_done_o), .code_o(s_code_o),
    .uniform_o(s_uniform_o), .progress_done_o(s_progress_done_o), .frame_valid_o(s_frame_valid_o),
    .frame_code_cnt_o(s_frame_code_cnt_o), .frame_uniform_cnt_o(s_frame_uniform_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [NB-1:0] code; logic uni; int due; } exp_t;
  typedef struct { int cc; int uc; int due; } frm_t;

  exp_t exp_q[$];
  frm_t frm_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   cnt = 0;
  int   ucnt = 0;

  function automatic logic [NB-1:0] model_code(input logic [1:0] m, input logic [NB*SW-1:0] s,
                                                input logic [9:0] sum);
    longint rhs;
    longint lhs;
    logic [NB-1:0] c;
    rhs = longint'(sum) * 25;
    for (int k = 0; k < NB; k++) begin
      lhs = longint'(s[k*SW +: SW]);
      case (m)
        2'd1:    c[k] = (lhs > rhs);
        2'd2:    c[k] = !(lhs >= rhs);
        default: c[k] = (lhs >= rhs);
      endcase
    end
    return c;
  endfunction

  function automatic logic model_uniform(input logic [NB-1:0] c);
    int t;
    t = 0;
    for (int k = 0; k < NB; k++) begin
      if (c[k] != c[(k + 1) % NB]) t++;
    end
    return (t <= 2);
  endfunction

  function automatic logic [NB*SW-1:0] mk_s(input logic [NB-1:0] c);
    logic [NB*SW-1:0] s;
    for (int k = 0; k < NB; k++) s[k*SW +: SW] = c[k] ? 24'd100 : 24'd0;
    return s;
  endfunction

  function automatic logic [NB*SW-1:0] rand_s(input logic [9:0] sum);
    logic [NB*SW-1:0] s;
    int rhs;
    rhs = int'(sum) * 25;
    for (int k = 0; k < NB; k++) begin
      case ($urandom_range(0, 3))
        0:       s[k*SW +: SW] = 24'(rhs > 0 ? rhs - 1 : 0);
        1:       s[k*SW +: SW] = 24'(rhs);
        2:       s[k*SW +: SW] = 24'(rhs + 1);
        default: s[k*SW +: SW] = 24'($urandom);
      endcase
    end
    return s;
  endfunction

  // Applies one cycle of stimulus at the falling edge and records expectations.
  task automatic drive(input logic pix, input logic pd, input logic r, input logic [1:0] m,
                       input logic [NB*SW-1:0] s, input logic [9:0] sum);
    exp_t e;
    frm_t f;
    logic [NB-1:0] c;
    @(negedge clk);
    rst = r; done_i = pix; progress_done_i = pd; mode_i = m; s_i = s; sum_i = sum;
    if (r) begin
      cnt = 0; ucnt = 0;
    end else begin
      if (pix) begin
        c = model_code(m, s, sum);
        e.code = c; e.uni = model_uniform(c); e.due = cyc + 2;
        exp_q.push_back(e);
        cnt++;
        ucnt += int'(e.uni);
      end
      if (pd) begin
        f.cc = cnt; f.uc = ucnt; f.due = cyc + 3;
        frm_q.push_back(f);
        cnt  = pix ? 1 : 0;
        ucnt = pix ? int'(model_uniform(c)) : 0;
      end
    end
  endtask

  task automatic do_reset(input int n);
    logic [9:0] sm;
    for (int i = 0; i < n; i++) begin
      sm = 10'($urandom);
      drive(1'b1, 1'b0, 1'b1, 2'($urandom), rand_s(sm), sm);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 2'd0, '0, 10'd0);
  endtask

  // Monitor: compares DUT responses with the scoreboard queues just after each edge.
  always @(posedge clk) begin
    exp_t e;
    frm_t f;
    logic [77:0] zs;
    int sat_cc, sat_uc;
    cyc++;
    #1;
    if (rst) begin
      zs = {done_o, code_o, uniform_o, progress_done_o, frame_valid_o, frame_code_cnt_o,
            frame_uniform_cnt_o, s_done_o, s_code_o, s_uniform_o, s_frame_valid_o,
            s_frame_code_cnt_o, s_frame_uniform_cnt_o, s_progress_done_o};
      checks++;
      if (zs !== '0) begin
        failures++;
        $display("FAIL reset_outputs got=%0h exp=0 cyc=%0d", zs, cyc);
      end
      exp_q.delete();
      frm_q.delete();
    end else begin
      if (done_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done got code=%0h cyc=%0d", code_o, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.due != cyc || code_o !== e.code || uniform_o !== e.uni ||
              s_done_o !== 1'b1 || s_code_o !== e.code) begin
            failures++;
            $display("FAIL pixel got cyc=%0d code=%0h uni=%0b exp cyc=%0d code=%0h uni=%0b",
                     cyc, code_o, uniform_o, e.due, e.code, e.uni);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_done got none exp code=%0h at cyc=%0d", e.code, e.due);
      end
      if (frame_valid_o) begin
        checks++;
        if (frm_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_frame got cc=%0d uc=%0d cyc=%0d",
                   frame_code_cnt_o, frame_uniform_cnt_o, cyc);
        end else begin
          f = frm_q.pop_front();
          sat_cc = (f.cc > 15) ? 15 : f.cc;
          sat_uc = (f.uc > 15) ? 15 : f.uc;
          if (f.due != cyc || int'(frame_code_cnt_o) != f.cc || int'(frame_uniform_cnt_o) != f.uc ||
              s_frame_valid_o !== 1'b1 || int'(s_frame_code_cnt_o) != sat_cc ||
              int'(s_frame_uniform_cnt_o) != sat_uc) begin
            failures++;
            $display("FAIL frame got cyc=%0d cc=%0d uc=%0d sat=%0d/%0d exp cyc=%0d cc=%0d uc=%0d sat=%0d/%0d",
                     cyc, frame_code_cnt_o, frame_uniform_cnt_o, s_frame_code_cnt_o,
                     s_frame_uniform_cnt_o, f.due, f.cc, f.uc, sat_cc, sat_uc);
          end
        end
      end else if (frm_q.size() > 0 && frm_q[0].due <= cyc) begin
        f = frm_q.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_frame got none exp cc=%0d uc=%0d at cyc=%0d", f.cc, f.uc, f.due);
      end
    end
  end

  initial begin
    logic [NB*SW-1:0] s2;
    logic [NB-1:0]    codes [10];
    logic [9:0]       sm;
    logic             pix;

    // Reset held with done_i asserted, then a pixel right at release.
    do_reset(3);
    drive(1'b1, 1'b0, 1'b0, 2'd0, rand_s(10'd7), 10'd7);

    s2 = {24'd100, 24'd50, 24'd100, 24'd200, 24'd0, 24'd101, 24'd99, 24'd100};
    drive(1'b1, 1'b0, 1'b0, 2'd0, s2, 10'd4);
    drive(1'b1, 1'b0, 1'b0, 2'd1, s2, 10'd4);
    drive(1'b1, 1'b0, 1'b0, 2'd2, rand_s(10'd0), 10'd0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, rand_s(10'd0), 10'd0);
    drive(1'b1, 1'b0, 1'b0, 2'd3, s2, 10'd4);
    idle(2);
    drive(1'b0, 1'b1, 1'b0, 2'd0, '0, 10'd0);
    idle(4);

    // Ten back-to-back pixels, six uniform, frame closes on the last one.
    codes = '{8'h00, 8'h55, 8'hFF, 8'h0F, 8'hAA, 8'hF0, 8'h5A, 8'h3C, 8'hB5, 8'h01};
    for (int i = 0; i < 10; i++) drive(1'b1, (i == 9), 1'b0, 2'd0, mk_s(codes[i]), 10'd4);
    idle(4);
    drive(1'b0, 1'b1, 1'b0, 2'd0, '0, 10'd0);
    drive(1'b0, 1'b1, 1'b0, 2'd0, '0, 10'd0);
    idle(4);

    // Twenty pixels in one frame saturate the narrow-counter instance.
    for (int i = 0; i < 20; i++) begin
      sm = 10'($urandom);
      drive(1'b1, (i == 19), 1'b0, 2'($urandom), rand_s(sm), sm);
    end
    idle(4);

    // Reset with two pixels in flight, then an empty frame and a fresh frame.
    drive(1'b1, 1'b0, 1'b0, 2'd0, mk_s(8'h0F), 10'd4);
    drive(1'b1, 1'b0, 1'b1, 2'd0, mk_s(8'h0F), 10'd4);
    do_reset(2);
    drive(1'b0, 1'b1, 1'b0, 2'd0, '0, 10'd0);
    for (int i = 0; i < 5; i++) drive(1'b1, (i == 4), 1'b0, 2'd0, mk_s(codes[i]), 10'd4);
    idle(4);

    // Randomized traffic with one mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset(2);
      sm  = 10'($urandom);
      pix = ($urandom_range(0, 3) != 0);
      drive(pix, ($urandom_range(0, 15) == 0), 1'b0, 2'($urandom), rand_s(sm), sm);
    end
    drive(1'b0, 1'b1, 1'b0, 2'd0, '0, 10'd0);
    idle(8);

    checks++;
    if (exp_q.size() != 0 || frm_q.size() != 0) begin
      failures++;
      $display("FAIL drain got pending pixels=%0d frames=%0d exp 0/0", exp_q.size(), frm_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
